// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit beside the execute-stage ALU.
// Shift-add multiplier (MUL_UNROLL bits/cycle) and restoring divider share one datapath.
module muldiv_unit #(
    parameter int XLEN       = 64,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            op_w,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam int U  = MUL_UNROLL;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        return XLEN'(x);
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      op_q, op_d;
    logic            w_q, w_d;
    logic            neg_q, neg_d;
    logic            negr_q, negr_d;
    logic            spec_q, spec_d;

    logic            w_in, a_sgn, b_sgn, sa, sb;
    logic            div_zero, div_ovf;
    logic [6:0]      len_in;
    logic [XLEN-1:0] a_l, b_l, mag_a, mag_b;
    logic [XLEN-1:0] min_neg, spec_val;

    // Accept-time decode: operand width, signedness, magnitudes, special cases
    always_comb begin
        w_in   = op_w && (XLEN == 64) && (op[2] || op[1:0] == 2'b00);
        a_sgn  = (op == 3'b001) || (op == 3'b010) ||
                 (op == 3'b100) || (op == 3'b110);
        b_sgn  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        len_in = w_in ? 7'd32 : 7'(XLEN);
        a_l    = a;
        b_l    = b;
        if (w_in) begin
            a_l = a_sgn ? sext32(a[31:0]) : zext32(a[31:0]);
            b_l = b_sgn ? sext32(b[31:0]) : zext32(b[31:0]);
        end
        sa      = a_sgn & a_l[XLEN-1];
        sb      = b_sgn & b_l[XLEN-1];
        mag_a   = sa ? -a_l : a_l;
        mag_b   = sb ? -b_l : b_l;
        min_neg = w_in ? sext32(32'h8000_0000)
                       : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = op[2] && (b_l == '0);
        div_ovf  = op[2] && !op[0] && (a_l == min_neg) && (b_l == '1);
        if (div_zero) begin
            spec_val = op[1] ? (w_in ? sext32(a[31:0]) : a) : '1;
        end else begin
            spec_val = op[1] ? '0 : a_l;
        end
    end

    logic [XLEN+U-1:0]   mul_sum;
    logic [2*XLEN+U-1:0] mul_sh;
    logic [XLEN:0]       rem_sh, rem_dif;
    logic                rem_ge;

    always_comb begin
        mul_sum = {{U{1'b0}}, hi_q} +
                  ({{U{1'b0}}, opb_q} * (XLEN+U)'(lo_q[U-1:0]));
        mul_sh  = {mul_sum, lo_q};
        rem_sh  = {hi_q, lo_q[XLEN-1]};
        rem_dif = rem_sh - {1'b0, opb_q};
        rem_ge  = rem_sh >= {1'b0, opb_q};
    end

    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   mul_res, quo, rmd, div_raw, div_res, fix;

    // Sign fixup and W sign-extension of the finished result
    always_comb begin
        mul_full = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        if (op_q[1:0] == 2'b00) begin
            mul_res = w_q ? sext32(lo_q[XLEN-1 -: 32]) : mul_full[XLEN-1:0];
        end else begin
            mul_res = mul_full[2*XLEN-1:XLEN];
        end
        quo     = neg_q ? -lo_q : lo_q;
        rmd     = negr_q ? -hi_q : hi_q;
        div_raw = op_q[1] ? rmd : quo;
        div_res = w_q ? sext32(div_raw[31:0]) : div_raw;
        fix     = spec_q ? lo_q : (op_q[2] ? div_res : mul_res);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        op_d     = op_q;
        w_d      = w_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        spec_d   = spec_q;
        result_d = result_q;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d   = op;
                    w_d    = w_in;
                    neg_d  = sa ^ sb;
                    negr_d = sa;
                    spec_d = div_zero || div_ovf;
                    opb_d  = mag_b;
                    hi_d   = '0;
                    lo_d   = (op[2] && w_in) ? (mag_a << (XLEN - 32)) : mag_a;
                    cnt_d  = op[2] ? CW'(len_in - 7'd1)
                                   : CW'(len_in / 7'(U) - 7'd1);
                    if (div_zero || div_ovf) begin
                        lo_d    = spec_val;
                        state_d = FIN;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2]) begin
                        hi_d = rem_ge ? rem_dif[XLEN-1:0] : rem_sh[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], rem_ge};
                    end else begin
                        hi_d = mul_sh[2*XLEN+U-1:XLEN+U];
                        lo_d = mul_sh[XLEN+U-1:U];
                    end
                    if (cnt_q == '0) state_d = FIN;
                    else cnt_d = cnt_q - 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    done     = 1'b1;
                    result_d = fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            w_q      <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            w_q      <= w_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            spec_q   <= spec_d;
            result_q <= result_d;
        end
    end

    assign busy   = state_q != IDLE;
    assign stall  = (start & ~done) | (busy & ~done);
    assign result = done ? fix : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random ops
// against an arithmetic reference model; MUL_UNROLL 1 and 4 run side by side.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, op_w, flush;
    logic [2:0]  op;
    logic [63:0] a, b;
    logic        busy, stall, done;
    logic        busy4, stall4, done4;
    logic [63:0] result, result4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64), .MUL_UNROLL(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_w(op_w),
        .a(a), .b(b), .flush(flush), .busy(busy), .stall(stall),
        .done(done), .result(result)
    );

    muldiv_unit #(.XLEN(64), .MUL_UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_w(op_w),
        .a(a), .b(b), .flush(flush), .busy(busy4), .stall(stall4),
        .done(done4), .result(result4)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic w,
                                            input logic [63:0] x,
                                            input logic [63:0] y);
        logic [127:0] px, py, pp;
        longint       sx, sy;
        int           wx, wy;
        logic [31:0]  r32;
        logic [63:0]  r64;
        logic         ovf32, ovf64;
        sx = x; sy = y;
        wx = x[31:0]; wy = y[31:0];
        r32 = '0; r64 = '0;
        ovf32 = (x[31:0] == 32'h8000_0000) && (y[31:0] == 32'hFFFF_FFFF);
        ovf64 = (x == 64'h8000_0000_0000_0000) && (y == '1);
        if (w && (o == 3'd0 || o[2])) begin
            case (o)
                3'd0: r32 = x[31:0] * y[31:0];
                3'd4: begin
                    if (y[31:0] == 0) r32 = '1;
                    else if (ovf32) r32 = x[31:0];
                    else r32 = wx / wy;
                end
                3'd5: begin
                    if (y[31:0] == 0) r32 = '1;
                    else r32 = x[31:0] / y[31:0];
                end
                3'd6: begin
                    if (y[31:0] == 0) r32 = x[31:0];
                    else if (ovf32) r32 = '0;
                    else r32 = wx % wy;
                end
                default: begin
                    if (y[31:0] == 0) r32 = x[31:0];
                    else r32 = x[31:0] % y[31:0];
                end
            endcase
            return {{32{r32[31]}}, r32};
        end
        px = {64'b0, x};
        py = {64'b0, y};
        case (o)
            3'd0: r64 = x * y;
            3'd1, 3'd2, 3'd3: begin
                if (o != 3'd3) px = {{64{x[63]}}, x};
                if (o == 3'd1) py = {{64{y[63]}}, y};
                pp = px * py;
                r64 = pp[127:64];
            end
            3'd4: begin
                if (y == 0) r64 = '1;
                else if (ovf64) r64 = x;
                else r64 = sx / sy;
            end
            3'd5: begin
                if (y == 0) r64 = '1;
                else r64 = x / y;
            end
            3'd6: begin
                if (y == 0) r64 = x;
                else if (ovf64) r64 = '0;
                else r64 = sx % sy;
            end
            default: begin
                if (y == 0) r64 = x;
                else r64 = x % y;
            end
        endcase
        return r64;
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic w,
                                   input logic [63:0] x, input logic [63:0] y,
                                   input int u);
        logic wd, zero, ovf;
        int   len;
        wd  = w && (o == 3'd0 || o[2]);
        len = wd ? 32 : 64;
        if (wd) begin
            zero = y[31:0] == 0;
            ovf  = !o[0] && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF;
        end else begin
            zero = y == 0;
            ovf  = !o[0] && x == 64'h8000_0000_0000_0000 && y == '1;
        end
        if (o[2]) return (zero || ovf) ? 1 : len + 1;
        return len / u + 1;
    endfunction

    // Issue one op, observe both units; cycle 0 is the accept cycle.
    task automatic run_op(input logic [2:0] o, input logic w,
                          input logic [63:0] x, input logic [63:0] y,
                          input logic keep_start,
                          output int dc, output logic [63:0] r,
                          output int dc4, output logic [63:0] r4,
                          output int nd, output int hs_err);
        logic exp_busy, exp_stall;
        dc = -1; dc4 = -1; nd = 0; hs_err = 0; r = 'x; r4 = 'x;
        @(negedge clk);
        op = o; op_w = w; a = x; b = y; start = 1'b1;
        #1;
        if (stall !== 1'b1 || busy !== 1'b0 || done !== 1'b0) hs_err++;
        @(posedge clk);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                if (dc < 0) begin dc = c; r = result; end
            end
            if (done4 === 1'b1 && dc4 < 0) begin dc4 = c; r4 = result4; end
            exp_busy  = (dc < 0) || (c == dc);
            exp_stall = (start || exp_busy) && (c != dc);
            if (busy !== exp_busy || stall !== exp_stall) hs_err++;
            if (!keep_start || c == dc) start = 1'b0;
            if (dc > 0 && dc4 > 0 && c >= dc + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = '0; op_w = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({busy, done, stall, busy4, done4} !== 5'b0 ||
            result !== 64'd0 || result4 !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset: busy=%b done=%b stall=%b res=%h, need 0",
                     busy, done, stall, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul_basic();
        int dc, dc4, nd, hs;
        logic [63:0] r, r4;
        run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0,
               dc, r, dc4, r4, nd, hs);
        tests_run += 4;
        if (r !== 64'hFFFF_FFFF_FFFF_FFEB || r4 !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            tests_failed++;
            $display("FAIL mul_res: got %h/%h need fff..ffeb", r, r4);
        end
        if (dc !== 65 || dc4 !== 17) begin
            tests_failed++;
            $display("FAIL mul_lat: got %0d/%0d need 65/17", dc, dc4);
        end
        if (hs !== 0) begin
            tests_failed++;
            $display("FAIL mul_stall: %0d busy/stall errors, need 0", hs);
        end
        if (nd !== 1) begin
            tests_failed++;
            $display("FAIL mul_ndone: got %0d need 1", nd);
        end
    endtask

    task automatic test_mulhu();
        int dc, dc4, nd, hs;
        logic [63:0] r, r4;
        run_op(3'd3, 1'b0, '1, '1, 1'b0, dc, r, dc4, r4, nd, hs);
        tests_run += 2;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE || r4 !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            tests_failed++;
            $display("FAIL mulhu_res: got %h/%h need fff..fffe", r, r4);
        end
        if (dc !== 65 || dc4 !== 17) begin
            tests_failed++;
            $display("FAIL mulhu_lat: got %0d/%0d need 65/17", dc, dc4);
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  ops [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [63:0] xs  [4] = '{64'd100, 64'd100,
                                 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] ys  [4] = '{64'd0, 64'd0, '1, '1};
        logic [63:0] es  [4] = '{'1, 64'd100, 64'h8000_0000_0000_0000, 64'd0};
        int dc, dc4, nd, hs;
        logic [63:0] r, r4;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 1'b0, xs[i], ys[i], 1'b0, dc, r, dc4, r4, nd, hs);
            tests_run += 2;
            if (r !== es[i] || r4 !== es[i]) begin
                tests_failed++;
                $display("FAIL special%0d_res: got %h need %h", i, r, es[i]);
            end
            if (dc !== 1 || dc4 !== 1 || hs !== 0) begin
                tests_failed++;
                $display("FAIL special%0d_lat: got %0d hs=%0d need 1", i, dc, hs);
            end
        end
    endtask

    task automatic test_word();
        logic [2:0]  ops [2] = '{3'd4, 3'd6};
        logic [63:0] es  [2] = '{64'hFFFF_FFFF_FFFF_FFFD, '1};
        int dc, dc4, nd, hs;
        logic [63:0] r, r4;
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 1'b0,
                   dc, r, dc4, r4, nd, hs);
            tests_run += 2;
            if (r !== es[i]) begin
                tests_failed++;
                $display("FAIL word%0d_res: got %h need %h", i, r, es[i]);
            end
            if (dc !== 33 || dc4 !== 33) begin
                tests_failed++;
                $display("FAIL word%0d_lat: got %0d need 33", i, dc);
            end
        end
    endtask

    task automatic test_flush();
        int dc, dc4, nd, hs, ndf;
        logic [63:0] r, r4;
        run_op(3'd5, 1'b0, 64'd100, 64'd7, 1'b0, dc, r, dc4, r4, nd, hs);
        tests_run++;
        if (r !== 64'd14) begin
            tests_failed++;
            $display("FAIL flush_pre: got %h need 14", r);
        end
        @(negedge clk);
        op = 3'd4; op_w = 1'b0; a = 64'd1000; b = 64'd7;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle: busy=%b need 0", busy);
        end
        flush = 1'b0;
        @(posedge clk);
        ndf = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndf++;
            if (c == 21) begin
                tests_run++;
                if (busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL flush_calc: busy=%b at cycle 21 need 0", busy);
                end
                flush = 1'b0;
            end
            if (c == 1) start = 1'b0;
            if (c == 20) flush = 1'b1;
        end
        tests_run++;
        if (ndf !== 0 || result !== 64'd14) begin
            tests_failed++;
            $display("FAIL flush_keep: dones=%0d res=%h need 0/14", ndf, result);
        end
        run_op(3'd5, 1'b0, 64'd1000, 64'd7, 1'b0, dc, r, dc4, r4, nd, hs);
        tests_run++;
        if (r !== 64'd142 || dc !== 65) begin
            tests_failed++;
            $display("FAIL flush_after: got %0d@%0d need 142@65", r, dc);
        end
        @(negedge clk);
        op = 3'd5; a = 64'd5; b = 64'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        #1;
        tests_run++;
        if (done !== 1'b0 || done4 !== 1'b0 || result !== 64'd142) begin
            tests_failed++;
            $display("FAIL flush_fin: done=%b res=%h need 0/142", done, result);
        end
        @(negedge clk);
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd142) begin
            tests_failed++;
            $display("FAIL flush_fin_post: busy=%b res=%h need 0/142", busy, result);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        nd = 0;
        @(negedge clk);
        op = 3'd0; op_w = 1'b0; a = 64'd9; b = 64'd11; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (c == 11) begin
                tests_run++;
                if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
                    tests_failed++;
                    $display("FAIL reset_mid: busy=%b done=%b res=%h need 0",
                             busy, done, result);
                end
                rst = 1'b0;
            end
            if (c == 1) start = 1'b0;
            if (c == 10) rst = 1'b1;
        end
        tests_run++;
        if (nd !== 0 || result !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_done: dones=%0d res=%h need 0", nd, result);
        end
    endtask

    task automatic test_start_while_busy();
        int dc, dc4, nd, hs;
        logic [63:0] r, r4;
        run_op(3'd5, 1'b0, 64'd123456789, 64'd1000, 1'b1, dc, r, dc4, r4, nd, hs);
        tests_run += 2;
        if (nd !== 1 || dc !== 65) begin
            tests_failed++;
            $display("FAIL busy_start: dones=%0d at %0d need 1 at 65", nd, dc);
        end
        if (r !== 64'd123456) begin
            tests_failed++;
            $display("FAIL busy_start_res: got %0d need 123456", r);
        end
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0, 1: v = {$urandom, $urandom};
            2: v = 64'($urandom_range(0, 100));
            3: v = -64'($urandom_range(1, 100));
            4: v = '0;
            5: v = '1;
            default: v = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000
                                              : {$urandom, 32'h8000_0000};
        endcase
        return v;
    endfunction

    task automatic test_random();
        int dc, dc4, nd, hs, el, el4;
        logic [63:0] r, r4, x, y, er;
        logic [2:0] o;
        logic w;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            x = rnd_operand();
            y = rnd_operand();
            er  = ref_res(o, w, x, y);
            el  = ref_lat(o, w, x, y, 1);
            el4 = ref_lat(o, w, x, y, 4);
            run_op(o, w, x, y, 1'b0, dc, r, dc4, r4, nd, hs);
            tests_run += 3;
            if (r !== er || r4 !== er) begin
                tests_failed++;
                $display("FAIL rnd%0d_res op=%0d w=%b a=%h b=%h: got %h/%h need %h",
                         i, o, w, x, y, r, r4, er);
            end
            if (dc !== el || dc4 !== el4) begin
                tests_failed++;
                $display("FAIL rnd%0d_lat op=%0d w=%b: got %0d/%0d need %0d/%0d",
                         i, o, w, dc, dc4, el, el4);
            end
            if (nd !== 1 || hs !== 0) begin
                tests_failed++;
                $display("FAIL rnd%0d_hs: dones=%0d errs=%0d need 1/0", i, nd, hs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mulhu();
        test_div_special();
        test_word();
        test_flush();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV64M multiply/divide unit. It attaches beside the execute-stage ALU of the 5-stage pipelined core. While it works, it holds the pipeline through a stall output and returns one result per accepted operation. It is parametrised in datapath width and multiply bits-per-cycle, and supports the RV64 word (W) variants, so it generalises the core's single-cycle integer datapath to multi-cycle M-extension operations.

Parameters:
XLEN, 64, datapath width in bits; must be 32 or 64.
MUL_UNROLL, 1, multiplier bits retired per cycle; allowed values 1, 2, 4, 8.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  request a new operation; sampled only in IDLE.
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_w  in  1  W variant (MULW/DIVW/DIVUW/REMW/REMUW); ignored for op 001–011 and when XLEN=32.
a  in  XLEN  rs1 operand; captured at accept.
b  in  XLEN  rs2 operand; captured at accept.
flush  in  1  abort the in-flight operation (branch/jump flush of the execute stage).
busy  out  1  high from the cycle after accept until done inclusive.
stall  out  1  equals start & ~done | busy & ~done; drives pipeline Stall_F/Stall_D and freezes the execute stage.
done  out  1  one-cycle pulse; result valid in this cycle.
result  out  XLEN  operation result; held after done until the next accept.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: busy=0, done=0, result=0, FSM=IDLE. Reset mid-operation discards all state; no done is produced.
- FSM states: IDLE, CALC, FIN.
  - IDLE → CALC on start (accept); operands and op are registered.
  - CALC counts down iterations; → FIN after the last iteration.
  - FIN asserts done for one cycle and performs sign/negation fixup and W sign-extension; → IDLE.
- Accept cycle is cycle 0. done rises in cycle N+1:
  - MUL*: N = L/MUL_UNROLL.
  - DIV/REM: N = L (restoring, 1 bit/cycle).
  - L = 32 when op_w=1, otherwise L = XLEN.
- Special cases (detected at accept, skip CALC, done in cycle 1):
  - Divisor zero: DIV/DIVU quotient = all ones (of width L, then sign-extended); REM/REMU result = dividend.
  - Signed overflow (dividend = most-negative of width L, divisor = −1): DIV result = dividend; REM result = 0.
- Signed handling: operands are converted to magnitudes at accept; the result is negated in FIN.
  - Quotient sign = sign(a) xor sign(b).
  - Remainder sign = sign(a).
  - MULHSU treats b as unsigned.
- Word ops: use a[31:0] and b[31:0]. The 32-bit result is sign-extended to XLEN; this applies to DIVUW/REMUW as well.
- MUL result = low XLEN bits of the product. MULH* result = high XLEN bits of the 2·XLEN-bit product.
- start while busy is ignored; no queueing. start in the same cycle as done is also ignored (IDLE not yet reached); the requester re-presents it the next cycle.
- flush:
  - In IDLE, flush with start suppresses the accept.
  - In CALC or FIN, flush returns the FSM to IDLE next cycle with busy=0, and done is not asserted. If flush coincides with FIN, done is suppressed.
  - result retains its previous value.
- rst dominates flush; flush dominates start.

Test Plan:
- MUL, a=7, b=0xFFFF_FFFF_FFFF_FFFD (−3), MUL_UNROLL=1 → done pulse in cycle 65, result 0xFFFF_FFFF_FFFF_FFEB; stall high cycles 0–64.
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE. Repeat with MUL_UNROLL=4 → done in cycle 17.
- DIV a=100, b=0 → done in cycle 1, result 0xFFFF_FFFF_FFFF_FFFF. REMU a=100, b=0 → result 100. DIV a=0x8000_0000_0000_0000, b=−1 → result 0x8000_0000_0000_0000. REM of the same operands → 0.
- DIVW, a=0x1234_5678_FFFF_FFF9 (low word −7), b=2 → done in cycle 33, result 0xFFFF_FFFF_FFFF_FFFD (−3). REMW of the same operands → 0xFFFF_FFFF_FFFF_FFFF (−1).
- DIV 1000/7 started, flush at cycle 20 → busy=0 in cycle 21, no done, result unchanged. Next start DIVU 1000/7 → 142 in cycle 65.
- rst asserted at cycle 10 of a MUL → busy=0, done=0, result=0 in the following cycle. start asserted while busy → ignored, and only one done is observed.
